lsu_mem_access: RTL and testbench

- Load/store unit between the execute stage and the data-memory port.
- Consumes the 4-bit memory-control code produced by control decode, plus the ALU address and the rs2 write data.
- Runs a req/ack handshake with data memory, generates byte enables and lane-replicated write data, and returns sign- or zero-extended load data.
- Stalls the pipeline while an access is outstanding, and reports misalignment and memory timeout.

---
 rtl/lsu_mem_access_pkg.sv | 20 ++
 rtl/lsu_mem_access_load_align.sv | 26 ++
 rtl/lsu_mem_access.sv | 170 +++++++++++++++++
 tb/tb_lsu_mem_access.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/lsu_mem_access_pkg.sv
// Memory-control encodings shared between control decode and the load/store unit.
package ControlTypeDefs;

  typedef enum logic [3:0] {
    MEM_LW   = 4'b0000,
    MEM_LH   = 4'b0001,
    MEM_LB   = 4'b0010,
    MEM_LHU  = 4'b0011,
    MEM_LBU  = 4'b0100,
    MEM_SW   = 4'b0101,
    MEM_SH   = 4'b0110,
    MEM_SB   = 4'b0111,
    MEM_NONE = 4'b1000
  } mem_ctrl_e;

  function automatic logic is_store(mem_ctrl_e code);
    return code inside {MEM_SW, MEM_SH, MEM_SB};
  endfunction

endpackage

// File: rtl/lsu_mem_access_load_align.sv
// Picks the addressed byte/half out of a read word and sign- or zero-extends it.
module lsu_load_align
  import ControlTypeDefs::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  offset_i,
  input  mem_ctrl_e   code_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word_i[8*offset_i +: 8];
    half_sel = offset_i[1] ? word_i[31:16] : word_i[15:0];
    case (code_i)
      MEM_LB:  data_o = {{24{byte_sel[7]}}, byte_sel};
      MEM_LBU: data_o = {24'd0, byte_sel};
      MEM_LH:  data_o = {{16{half_sel[15]}}, half_sel};
      MEM_LHU: data_o = {16'd0, half_sel};
      default: data_o = word_i;
    endcase
  end

endmodule

// File: rtl/lsu_mem_access.sv
// Load/store unit: accepts one access at a time, runs the req/ack handshake with
// data memory and reports load results, misalignment and memory timeouts.
module lsu_mem_access
  import ControlTypeDefs::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  iClk,
  input  logic                  iRstN,
  input  logic                  iValid,
  input  logic [3:0]            iMemControl,
  input  logic [ADDR_WIDTH-1:0] iAddr,
  input  logic [31:0]           iWriteData,
  output logic                  oStall,
  output logic [31:0]           oLoadData,
  output logic                  oLoadValid,
  output logic                  oMisaligned,
  output logic                  oBusError,
  output logic                  oMemReq,
  output logic                  oMemWe,
  output logic [ADDR_WIDTH-1:0] oMemAddr,
  output logic [3:0]            oMemByteEn,
  output logic [31:0]           oMemWdata,
  input  logic                  iMemAck,
  input  logic [31:0]           iMemRdata
);

  localparam int CntW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE, S_ERR} state_e;

  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  mem_ctrl_e             code_q, code_d;
  logic [1:0]            off_q, off_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  we_q, we_d;
  logic [3:0]            be_q, be_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [31:0]           load_data_q, load_data_d;
  logic                  mis_q, mis_d;

  mem_ctrl_e   code_in;
  logic        aligned;
  logic [3:0]  be_in;
  logic [31:0] wdata_in;
  logic [31:0] aligned_word;
  logic        stall;

  lsu_load_align u_align (
    .word_i   (iMemRdata),
    .offset_i (off_q),
    .code_i   (code_q),
    .data_o   (aligned_word)
  );

  // Decode of the incoming request: alignment, lane enables, replicated data.
  always_comb begin
    code_in = iMemControl[3] ? MEM_NONE : mem_ctrl_e'(iMemControl);
    case (code_in)
      MEM_LW, MEM_SW:          aligned = (iAddr[1:0] == 2'b00);
      MEM_LH, MEM_LHU, MEM_SH: aligned = ~iAddr[0];
      default:                 aligned = 1'b1;
    endcase
    case (code_in)
      MEM_SH:  be_in = iAddr[1] ? 4'b1100 : 4'b0011;
      MEM_SB:  be_in = 4'b0001 << iAddr[1:0];
      default: be_in = 4'b1111;
    endcase
    case (code_in)
      MEM_SH:  wdata_in = {2{iWriteData[15:0]}};
      MEM_SB:  wdata_in = {4{iWriteData[7:0]}};
      default: wdata_in = iWriteData;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    code_d      = code_q;
    off_d       = off_q;
    addr_d      = addr_q;
    we_d        = we_q;
    be_d        = be_q;
    wdata_d     = wdata_q;
    load_data_d = load_data_q;
    mis_d       = 1'b0;
    stall       = 1'b0;
    oMemReq     = 1'b0;
    oLoadValid  = 1'b0;
    oBusError   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (iValid && code_in != MEM_NONE) begin
          if (aligned) begin
            stall   = 1'b1;
            code_d  = code_in;
            off_d   = iAddr[1:0];
            addr_d  = {iAddr[ADDR_WIDTH-1:2], 2'b00};
            we_d    = is_store(code_in);
            be_d    = be_in;
            wdata_d = wdata_in;
            cnt_d   = '0;
            state_d = S_REQ;
          end else begin
            mis_d = 1'b1;
          end
        end
      end
      S_REQ: begin
        oMemReq = 1'b1;
        stall   = 1'b1;
        cnt_d   = cnt_q + CntW'(1);
        // Ack is checked first so a same-cycle ack beats the timeout.
        if (iMemAck) begin
          if (!we_q) load_data_d = aligned_word;
          state_d = S_DONE;
        end else if (cnt_d == CntW'(TIMEOUT_CYCLES)) begin
          state_d = S_ERR;
        end
      end
      S_DONE: begin
        oLoadValid = ~we_q;
        state_d    = S_IDLE;
      end
      S_ERR: begin
        oBusError = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Stall is partly combinational, so it is forced low while reset is held.
  assign oStall      = stall & iRstN;
  assign oLoadData   = load_data_q;
  assign oMisaligned = mis_q;
  assign oMemWe      = we_q;
  assign oMemAddr    = addr_q;
  assign oMemByteEn  = be_q;
  assign oMemWdata   = wdata_q;

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      code_q      <= MEM_NONE;
      off_q       <= 2'b00;
      addr_q      <= '0;
      we_q        <= 1'b0;
      be_q        <= 4'b0000;
      wdata_q     <= 32'd0;
      load_data_q <= 32'd0;
      mis_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      code_q      <= code_d;
      off_q       <= off_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      be_q        <= be_d;
      wdata_q     <= wdata_d;
      load_data_q <= load_data_d;
      mis_q       <= mis_d;
    end
  end

endmodule

// File: tb/tb_lsu_mem_access.sv
// Directed and random accesses against lsu_mem_access, checked with a byte-lane model.
module tb_lsu_mem_access;

  localparam int TO = 4;

  logic        iClk, iRstN, iValid, iMemAck;
  logic [3:0]  iMemControl;
  logic [31:0] iAddr, iWriteData, iMemRdata;
  logic        oStall, oLoadValid, oMisaligned, oBusError, oMemReq, oMemWe;
  logic [31:0] oLoadData, oMemAddr, oMemWdata;
  logic [3:0]  oMemByteEn;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_ld = 32'd0;

  lsu_mem_access #(.ADDR_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
    .iClk(iClk), .iRstN(iRstN), .iValid(iValid), .iMemControl(iMemControl),
    .iAddr(iAddr), .iWriteData(iWriteData), .oStall(oStall), .oLoadData(oLoadData),
    .oLoadValid(oLoadValid), .oMisaligned(oMisaligned), .oBusError(oBusError),
    .oMemReq(oMemReq), .oMemWe(oMemWe), .oMemAddr(oMemAddr), .oMemByteEn(oMemByteEn),
    .oMemWdata(oMemWdata), .iMemAck(iMemAck), .iMemRdata(iMemRdata)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  // Access size in bytes; 0 for the no-op codes.
  function automatic int size_of(logic [3:0] c);
    case (c)
      4'd0, 4'd5:       return 4;
      4'd1, 4'd3, 4'd6: return 2;
      4'd2, 4'd4, 4'd7: return 1;
      default:          return 0;
    endcase
  endfunction

  function automatic bit is_st(logic [3:0] c);
    return (c >= 4'd5) && (c <= 4'd7);
  endfunction

  function automatic logic [3:0] model_be(logic [3:0] c, logic [31:0] a);
    int s, base;
    s = size_of(c);
    if (!is_st(c)) return 4'hF;
    base = (int'(a % 4) / s) * s;
    return 4'(((1 << s) - 1) << base);
  endfunction

  function automatic logic [31:0] model_wd(logic [3:0] c, logic [31:0] wd);
    if (c == 4'd6) return {16'd0, wd[15:0]} * 32'h0001_0001;
    if (c == 4'd7) return {24'd0, wd[7:0]} * 32'h0101_0101;
    return wd;
  endfunction

  function automatic logic [31:0] model_load(logic [3:0] c, logic [31:0] a, logic [31:0] rd);
    longint unsigned v;
    int bits;
    bits = 8 * size_of(c);
    v = ({32'd0, rd} >> (8 * (a % 4))) & ((64'd1 << bits) - 64'd1);
    if ((c == 4'd1 || c == 4'd2) && v[bits-1]) v = v - (64'd1 << bits);
    return v[31:0];
  endfunction

  // ack_at = REQ cycle index (0-based) carrying the ack; >= TO means never.
  task automatic access(input logic [3:0] c, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] rd, input int ack_at);
    int  s;
    bit  legal, mis, acked, st;
    s     = size_of(c);
    legal = (s != 0) && ((a % s) == 0);
    mis   = (s != 0) && !legal;
    st    = is_st(c);
    acked = 1'b0;
    iValid = 1'b1; iMemControl = c; iAddr = a; iWriteData = wd;
    #1;
    chk("stall_accept", {31'd0, oStall}, {31'd0, legal});
    chk("req_accept", {31'd0, oMemReq}, 32'd0);
    tick();
    iValid = 1'b0; iMemControl = 4'b1000;
    if (!legal) begin
      chk("misaligned", {31'd0, oMisaligned}, {31'd0, mis});
      chk("req_idle", {31'd0, oMemReq}, 32'd0);
      chk("stall_idle", {31'd0, oStall}, 32'd0);
      tick();
      chk("mis_clear", {31'd0, oMisaligned}, 32'd0);
      $display("access code=%0d addr=0x%08h rejected mis=%0d", c, a, mis);
      return;
    end
    for (int n = 0; n < TO && !acked; n++) begin
      chk("req_high", {31'd0, oMemReq}, 32'd1);
      chk("stall_req", {31'd0, oStall}, 32'd1);
      chk("mem_addr", oMemAddr, a & 32'hFFFF_FFFC);
      chk("mem_we", {31'd0, oMemWe}, {31'd0, st});
      chk("byte_en", {28'd0, oMemByteEn}, {28'd0, model_be(c, a)});
      if (st) chk("wdata", oMemWdata, model_wd(c, wd));
      iMemAck   = (n == ack_at);
      iMemRdata = (n == ack_at) ? rd : $urandom;
      tick();
      iMemAck = 1'b0;
      if (n == ack_at) acked = 1'b1;
    end
    chk("req_after", {31'd0, oMemReq}, 32'd0);
    chk("stall_after", {31'd0, oStall}, 32'd0);
    if (acked) begin
      if (!st) exp_ld = model_load(c, a, rd);
      chk("load_valid", {31'd0, oLoadValid}, {31'd0, !st});
      chk("bus_err_ok", {31'd0, oBusError}, 32'd0);
    end else begin
      chk("bus_err", {31'd0, oBusError}, 32'd1);
      chk("no_load_valid", {31'd0, oLoadValid}, 32'd0);
    end
    chk("load_data", oLoadData, exp_ld);
    tick();
    chk("pulse_clear", {30'd0, oLoadValid, oBusError}, 32'd0);
    $display("access code=%0d addr=0x%08h ack_at=%0d acked=%0d load=0x%08h", c, a, ack_at, acked, oLoadData);
  endtask

  initial begin
    iRstN = 1'b0; iValid = 1'b0; iMemControl = 4'b1000; iAddr = 32'd0;
    iWriteData = 32'd0; iMemAck = 1'b0; iMemRdata = 32'd0;
    #12;
    chk("rst_stall", {31'd0, oStall}, 32'd0);
    chk("rst_req", {31'd0, oMemReq}, 32'd0);
    chk("rst_flags", {29'd0, oLoadValid, oMisaligned, oBusError}, 32'd0);
    chk("rst_load", oLoadData, 32'd0);
    chk("rst_addr", oMemAddr, 32'd0);
    chk("rst_be_we", {27'd0, oMemByteEn, oMemWe}, 32'd0);
    chk("rst_wdata", oMemWdata, 32'd0);
    iRstN = 1'b1;
    tick();

    access(4'd0, 32'h100, 32'd0, 32'hDEADBEEF, 0);
    access(4'd2, 32'h103, 32'd0, 32'h80123456, 0);
    chk("lb_sign", oLoadData, 32'hFFFFFF80);
    access(4'd4, 32'h103, 32'd0, 32'h80123456, 0);
    chk("lbu_zero", oLoadData, 32'h00000080);
    access(4'd3, 32'h102, 32'd0, 32'h80123456, 1);
    chk("lhu_zero", oLoadData, 32'h00008012);
    access(4'd7, 32'h201, 32'h000000A5, 32'd0, 0);
    access(4'd0, 32'h102, 32'd0, 32'd0, 0);
    access(4'd6, 32'h301, 32'h1234, 32'd0, 0);
    access(4'd0, 32'h400, 32'd0, 32'h11111111, TO);
    access(4'd0, 32'h404, 32'd0, 32'h22222222, TO - 1);

    iValid = 1'b1; iMemControl = 4'b1011; iAddr = 32'h1;
    #1;
    chk("none_stall", {31'd0, oStall}, 32'd0);
    tick();
    iValid = 1'b0;
    chk("none_req", {30'd0, oMemReq, oMisaligned}, 32'd0);

    iMemAck = 1'b1; iMemRdata = 32'hCAFEF00D;
    tick();
    iMemAck = 1'b0;
    chk("stray_ack_valid", {31'd0, oLoadValid}, 32'd0);
    chk("stray_ack_data", oLoadData, exp_ld);

    iValid = 1'b1; iMemControl = 4'd0; iAddr = 32'h500;
    tick();
    iValid = 1'b0; iMemControl = 4'b1000;
    chk("pre_rst_req", {31'd0, oMemReq}, 32'd1);
    #2 iRstN = 1'b0;
    #1;
    chk("async_rst_req", {31'd0, oMemReq}, 32'd0);
    chk("async_rst_stall", {31'd0, oStall}, 32'd0);
    chk("async_rst_addr", oMemAddr, 32'd0);
    exp_ld = 32'd0;
    tick();
    iRstN = 1'b1;
    tick();
    access(4'd5, 32'h600, 32'h89ABCDEF, 32'd0, 2);

    for (int i = 0; i < 60; i++) begin
      access(4'($urandom_range(0, 9)), $urandom, $urandom, $urandom, int'($urandom_range(0, TO)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
